bus_responder: RTL and testbench

Memory-side responder for the 4-bit processor bus: the target that answers the address/data/control transfers issued by the processor's bus interface. It samples a request, services it from an internal 16×4 register file after a programmable number of wait states, and signals completion with an active-low `Ready`. Read data is driven with an explicit output-enable rather than tri-state. Writes to protected locations are refused and flagged.

---
 rtl/bus_responder.sv | 145 ++++++++++++++
 tb/tb_bus_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// bus_responder: memory-side target for the 4-bit processor bus.
// Captures a request, waits WAIT_STATES cycles, then answers for one cycle
// with an active-low Ready pulse from a 16x4 register file.
module bus_responder #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] RO_MASK     = 16'h0000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Addr_In,
    input  logic [3:0] D_In,
    input  logic [2:0] Ctrl_In,
    output logic [3:0] D_Out,
    output logic       D_Oe,
    output logic       Ready,
    output logic       Err
);

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned DEPTH = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [AW-1:0]    addr_q,  addr_d;
    logic [DW-1:0]    data_q,  data_d;
    logic             rd_q,    rd_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DW-1:0]    dout_q,  dout_d;
    logic             doe_q,   doe_d;
    logic             ready_q, ready_d;
    logic             err_q,   err_d;

    logic strobe;
    logic unused_ctrl;

    assign strobe      = Ctrl_In[0];
    assign unused_ctrl = Ctrl_In[1];

    assign D_Out = dout_q;
    assign D_Oe  = doe_q;
    assign Ready = ready_q;
    assign Err   = err_q;

    // Next-state, memory update and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        dout_d  = '0;
        doe_d   = 1'b0;
        ready_d = 1'b1;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    addr_d = Addr_In;
                    data_d = D_In;
                    rd_d   = Ctrl_In[2];
                    cnt_d  = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (!rd_q && !RO_MASK[addr_q]) begin
                    mem_d[addr_q] = data_q;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!strobe) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are prepared on entry to RESPOND.
        // No write can be pending here, so mem_q already holds current data.
        if (state_d == S_RESPOND) begin
            ready_d = 1'b0;
            if (rd_d) begin
                doe_d  = 1'b1;
                dout_d = mem_q[addr_d];
            end else begin
                err_d = RO_MASK[addr_d];
            end
        end
    end

    // State, capture, memory and output registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: three instances with different
// WAIT_STATES / RO_MASK settings, expected responses queued at issue time.
`timescale 1ns/1ps
module tb_bus_responder;

    typedef struct {
        int         dut;
        int         cyc;
        logic       doe;
        logic [3:0] dout;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] addr [3];
    logic [3:0] din  [3];
    logic [2:0] ctrl [3];
    logic [3:0] dout [3];
    logic       doe  [3];
    logic       rdy  [3];
    logic       err  [3];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq [$];

    // index 0: W=1, RO=0x0010; index 1: W=0; index 2: W=3
    bus_responder #(.WAIT_STATES(1), .RO_MASK(16'h0010)) u_dut_w1 (
        .Clk(clk), .Rst(rst), .Addr_In(addr[0]), .D_In(din[0]), .Ctrl_In(ctrl[0]),
        .D_Out(dout[0]), .D_Oe(doe[0]), .Ready(rdy[0]), .Err(err[0]));
    bus_responder #(.WAIT_STATES(0), .RO_MASK(16'h0000)) u_dut_w0 (
        .Clk(clk), .Rst(rst), .Addr_In(addr[1]), .D_In(din[1]), .Ctrl_In(ctrl[1]),
        .D_Out(dout[1]), .D_Oe(doe[1]), .Ready(rdy[1]), .Err(err[1]));
    bus_responder #(.WAIT_STATES(3), .RO_MASK(16'h0000)) u_dut_w3 (
        .Clk(clk), .Rst(rst), .Addr_In(addr[2]), .D_In(din[2]), .Ctrl_In(ctrl[2]),
        .D_Out(dout[2]), .D_Oe(doe[2]), .Ready(rdy[2]), .Err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // One transfer: queue expectation, strobe for 'hold' cycles, scramble
    // address/data/direction right after capture, then idle.
    task automatic xfer(input int i, input logic rd, input logic [3:0] a,
                        input logic [3:0] d, input logic [3:0] exp_d,
                        input logic exp_e, input int hold);
        exp_t e;
        @(negedge clk);
        e.dut  = i;
        e.cyc  = cyc + 1 + ws(i);
        e.doe  = rd;
        e.dout = rd ? exp_d : 4'h0;
        e.err  = exp_e;
        sbq.push_back(e);
        addr[i] = a;
        din[i]  = d;
        ctrl[i] = {rd, 1'b1, 1'b1};
        @(negedge clk);
        addr[i]    = ~a;
        din[i]     = ~d;
        ctrl[i][2] = ~rd;
        repeat (hold - 1) @(negedge clk);
        ctrl[i] = 3'b000;
        repeat (10) @(negedge clk);
    endtask

    // Monitor: every Ready pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rdy[i] == 1'b0) begin
                    if (sbq.size() == 0 || sbq[0].dut != i) begin
                        errors++;
                        $display("FAIL unexpected_ready: dut=%0d cyc=%0d", i, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (cyc != e.cyc || doe[i] !== e.doe || dout[i] !== e.dout || err[i] !== e.err) begin
                            errors++;
                            $display("FAIL response dut=%0d: got cyc=%0d oe=%b d=%h err=%b expected cyc=%0d oe=%b d=%h err=%b",
                                     i, cyc, doe[i], dout[i], err[i], e.cyc, e.doe, e.dout, e.err);
                        end
                    end
                end else if (doe[i] !== 1'b0 || err[i] !== 1'b0 || dout[i] !== 4'h0) begin
                    errors++;
                    $display("FAIL idle_outputs dut=%0d: oe=%b err=%b d=%h expected 0 0 0",
                             i, doe[i], err[i], dout[i]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 4'h0;
            din[i]  = 4'h0;
            ctrl[i] = 3'b000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), {3'b0, rdy[i]}, 4'h1);
            chk($sformatf("rst_oe%0d", i),    {3'b0, doe[i]}, 4'h0);
            chk($sformatf("rst_dout%0d", i),  dout[i],        4'h0);
            chk($sformatf("rst_err%0d", i),   {3'b0, err[i]}, 4'h0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // W=1: read of cleared memory, write/read round trip
        xfer(0, 1'b1, 4'h5, 4'h0, 4'h0, 1'b0, 1);
        xfer(0, 1'b0, 4'h3, 4'hA, 4'h0, 1'b0, 1);
        xfer(0, 1'b1, 4'h3, 4'h0, 4'hA, 1'b0, 1);

        // Asynchronous reset in the middle of a read RESPOND cycle
        xfer(0, 1'b0, 4'h1, 4'hC, 4'h0, 1'b0, 1);
        @(negedge clk);
        addr[0] = 4'h1;
        ctrl[0] = 3'b101;
        @(negedge clk);
        ctrl[0] = 3'b000;
        @(posedge clk);
        #1;
        chk("pre_rst_ready", {3'b0, rdy[0]}, 4'h0);
        chk("pre_rst_oe",    {3'b0, doe[0]}, 4'h1);
        chk("pre_rst_dout",  dout[0],        4'hC);
        #1 rst = 1'b1;
        #1;
        chk("async_ready", {3'b0, rdy[0]}, 4'h1);
        chk("async_oe",    {3'b0, doe[0]}, 4'h0);
        chk("async_dout",  dout[0],        4'h0);
        chk("async_err",   {3'b0, err[0]}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        xfer(0, 1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 1);

        // Read-only protection on location 4, neighbour 5 still writable
        xfer(0, 1'b0, 4'h4, 4'hF, 4'h0, 1'b1, 1);
        xfer(0, 1'b1, 4'h4, 4'h0, 4'h0, 1'b0, 1);
        xfer(0, 1'b0, 4'h5, 4'h7, 4'h0, 1'b0, 1);
        xfer(0, 1'b1, 4'h5, 4'h0, 4'h7, 1'b0, 1);

        // Strobe held for 10 cycles yields a single response
        xfer(0, 1'b0, 4'h6, 4'h5, 4'h0, 1'b0, 10);
        xfer(0, 1'b1, 4'h6, 4'h0, 4'h5, 1'b0, 1);

        // W=0: next-cycle response, address boundary 15
        xfer(1, 1'b0, 4'h7, 4'h6, 4'h0, 1'b0, 1);
        xfer(1, 1'b1, 4'h7, 4'h0, 4'h6, 1'b0, 1);
        xfer(1, 1'b0, 4'hF, 4'h9, 4'h0, 1'b0, 1);
        xfer(1, 1'b1, 4'hF, 4'h0, 4'h9, 1'b0, 1);
        xfer(1, 1'b0, 4'h4, 4'h3, 4'h0, 1'b0, 1);
        xfer(1, 1'b1, 4'h4, 4'h0, 4'h3, 1'b0, 1);

        // W=3: normal latency, then reset during WAIT discards the write
        xfer(2, 1'b0, 4'h0, 4'h3, 4'h0, 1'b0, 1);
        xfer(2, 1'b1, 4'h0, 4'h0, 4'h3, 1'b0, 1);
        @(negedge clk);
        addr[2] = 4'h2;
        din[2]  = 4'h9;
        ctrl[2] = 3'b001;
        @(negedge clk);
        ctrl[2] = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        xfer(2, 1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1);
        xfer(2, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1);

        repeat (5) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_ready: %0d responses outstanding, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
